wb_write_queue: RTL and testbench

WB_WRITE_QUEUE -- requirements
Module: wb_write_queue

---
 rtl/wb_write_queue.sv | 90 +++++++++
 tb/tb_wb_write_queue.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/wb_write_queue.sv
// Register-file write queue: merges ALU (A, priority) and load (B) results into a
// circular FIFO that retires one write per cycle through the register-file write port.
module wb_write_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     a_valid,
  input  logic [4:0]               a_addr,
  input  logic [63:0]              a_data,
  output logic                     a_ready,
  input  logic                     b_valid,
  input  logic [4:0]               b_addr,
  input  logic [63:0]              b_data,
  output logic                     b_ready,
  input  logic                     stall,
  output logic                     we3,
  output logic [4:0]               wa3,
  output logic [63:0]              wd3,
  input  logic [4:0]               q_addr,
  output logic                     q_pending,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]    addr_mem [DEPTH];
  logic [63:0]   data_mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          full;
  logic          empty;
  logic          take_a;
  logic          take_b;
  logic          push;
  logic          pop;
  logic [4:0]    push_addr;
  logic [63:0]   push_data;
  logic [DEPTH-1:0] hit;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // Readiness depends only on occupancy, so a pop in the same cycle never frees a slot early.
  assign a_ready = !full;
  assign b_ready = !full && !a_valid;

  assign take_a    = a_valid && a_ready;
  assign take_b    = b_valid && b_ready;
  assign push_addr = take_a ? a_addr : b_addr;
  assign push_data = take_a ? a_data : b_data;
  // Writes to XZR complete the handshake but never occupy a slot.
  assign push      = (take_a || take_b) && (push_addr != 5'd31);

  assign we3 = !empty && !stall;
  assign pop = we3;
  assign wa3 = empty ? 5'd0  : addr_mem[rd_ptr];
  assign wd3 = empty ? 64'd0 : data_mem[rd_ptr];

  // Hazard lookup: an entry is live when its distance from the head is below the occupancy.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cam
    logic [AW-1:0] ofs;
    assign ofs     = AW'(gi) - rd_ptr;
    assign hit[gi] = (CW'(ofs) < count) && (addr_mem[gi] == q_addr);
  end
  assign q_pending = (q_addr != 5'd31) && (|hit);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset; occupancy alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= push_addr;
      data_mem[wr_ptr] <= push_data;
    end
  end
endmodule

// File: tb/tb_wb_write_queue.sv
// Directed bench for wb_write_queue: expected writes go into a scoreboard as requests
// are driven and are matched against the write port at every falling edge.
module tb_wb_write_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, b_valid, stall;
  logic [4:0]  a_addr, b_addr, q_addr;
  logic [63:0] a_data, b_data;
  logic        a_ready, b_ready, we3, q_pending;
  logic [4:0]  wa3;
  logic [63:0] wd3;
  logic [$clog2(DEPTH):0] count;

  int tests = 0;
  int fails = 0;
  logic [68:0] sb [$];

  wb_write_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .stall(stall), .we3(we3), .wa3(wa3), .wd3(wd3),
    .q_addr(q_addr), .q_pending(q_pending), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Write-port monitor: every retired write must be the oldest outstanding expectation.
  always @(negedge clk) begin
    if (we3 === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_write", {59'd0, wa3}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        logic [68:0] e;
        e = sb.pop_front();
        check("wr_addr", {59'd0, wa3}, {59'd0, e[68:64]});
        check("wr_data", wd3, e[63:0]);
        $display("[TB] write wa3=%0d wd3=%0h", wa3, wd3);
      end
    end
  end

  initial begin
    reset = 1'b1; stall = 1'b0; q_addr = 5'd0;
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;
    #1;
    check("rst_we3", we3, 0);
    check("rst_wa3", wa3, 0);
    check("rst_wd3", wd3, 0);
    check("rst_qpend", q_pending, 0);
    check("rst_a_ready", a_ready, 1);
    check("rst_b_ready", b_ready, 1);
    check("rst_count", count, 0);
    a_valid = 1'b1; #1;
    check("rst_b_ready_avalid", b_ready, 0);
    a_valid = 1'b0;
    @(negedge clk); reset = 1'b0;
    cycle();

    // Single A push into an empty queue: one-cycle latency
    a_valid = 1'b1; a_addr = 5'd5; a_data = 64'h1234; sb.push_back({5'd5, 64'h1234});
    cycle();
    a_valid = 1'b0; #1;
    check("t1_count", count, 1);
    check("t1_we3", we3, 1);
    check("t1_wa3", wa3, 5);
    check("t1_wd3", wd3, 64'h1234);
    cycle();
    check("t1_count_after", count, 0);
    check("t1_we3_after", we3, 0);

    // A and B together: A wins both cycles, B goes after
    a_valid = 1'b1; a_addr = 5'd1; a_data = 64'hA; sb.push_back({5'd1, 64'hA});
    b_valid = 1'b1; b_addr = 5'd3; b_data = 64'hC;
    #1;
    check("t2_b_ready0", b_ready, 0);
    check("t2_a_ready", a_ready, 1);
    cycle();
    a_addr = 5'd2; a_data = 64'hB; sb.push_back({5'd2, 64'hB});
    #1;
    check("t2_b_ready1", b_ready, 0);
    cycle();
    a_valid = 1'b0; sb.push_back({5'd3, 64'hC});
    #1;
    check("t2_b_ready2", b_ready, 1);
    cycle();
    b_valid = 1'b0;
    cycle(); cycle();
    check("t2_drained", count, 0);

    // XZR push: handshake only
    a_valid = 1'b1; a_addr = 5'd31; a_data = 64'hFF;
    #1;
    check("t4_a_ready", a_ready, 1);
    cycle();
    a_valid = 1'b0; #1;
    check("t4_count", count, 0);
    check("t4_we3", we3, 0);
    cycle();
    check("t4_we3_later", we3, 0);

    // Hazard lookup with x7 queued under stall
    stall = 1'b1;
    a_valid = 1'b1; a_addr = 5'd7; a_data = 64'h77; sb.push_back({5'd7, 64'h77});
    cycle();
    a_addr = 5'd9; a_data = 64'h99; sb.push_back({5'd9, 64'h99});
    cycle();
    a_valid = 1'b0; q_addr = 5'd7; #1;
    check("t5_pend7", q_pending, 1);
    q_addr = 5'd8; #1;
    check("t5_pend8", q_pending, 0);
    q_addr = 5'd7; stall = 1'b0; #1;
    check("t5_pend7_head", q_pending, 1);
    check("t5_we3", we3, 1);
    cycle();
    check("t5_pend7_popped", q_pending, 0);
    check("t5_count", count, 1);
    cycle();
    check("t5_drained", count, 0);

    // Fill under stall, overflow attempt, then drain across the pointer wrap
    stall = 1'b1;
    for (int i = 0; i <= DEPTH; i++) begin
      a_valid = 1'b1; a_addr = 5'(10 + i); a_data = 64'(i + 64'h100);
      if (i < DEPTH) sb.push_back({5'(10 + i), 64'(i + 64'h100)});
      else begin #1; check("t3_full_a_ready", a_ready, 0); end
      cycle();
    end
    a_valid = 1'b0; #1;
    check("t3_count_sat", count, DEPTH);
    check("t3_we3_stalled", we3, 0);
    check("t3_a_ready", a_ready, 0);
    stall = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      #1;
      check("t3_drain_we3", we3, 1);
      check("t3_drain_wa3", wa3, 64'(10 + k));
      cycle();
    end
    check("t3_count_end", count, 0);
    check("t3_we3_end", we3, 0);

    // Reset mid-operation discards queued entries
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_valid = 1'b1; a_addr = 5'(20 + i); a_data = 64'(i);
      cycle();
    end
    a_valid = 1'b0; #1;
    check("t6_count3", count, 3);
    #1; reset = 1'b1; stall = 1'b0; #1;
    check("t6_rst_count", count, 0);
    check("t6_rst_we3", we3, 0);
    check("t6_rst_wa3", wa3, 0);
    @(negedge clk); @(negedge clk); reset = 1'b0;
    cycle();
    check("t6_post_we3", we3, 0);
    check("t6_post_count", count, 0);
    cycle(); cycle();
    check("sb_empty", 64'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
